// File: rtl/product_display_pkg.sv
// Shared constants for the product display: digit codes, segment patterns,
// FSM states and the double-dabble nibble adjust.
package product_display_pkg;

    localparam int BCD_W = 20;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W/4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/product_display_seg7_decoder.sv
// Digit code to active-low 7-segment pattern; unknown codes are blank.
module seg7_decoder
    import product_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            DIG_MINUS: seg_o = SEG_MINUS;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/product_display.sv
// Captures a signed 16-bit product, converts it to sign + BCD sequentially and
// scans it onto a 4-digit multiplexed 7-segment display.
module product_display
    import product_display_pkg::*;
#(
    parameter int REFRESH_CNT = 100000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] product,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [15:0]        mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [3:0]         shcnt_q, shcnt_d;
    logic [3:0][3:0]    disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W+15:0]  shifted;

    logic [3:0][3:0]    fmt_code;
    logic               fmt_ovf, fmt_lead, fmt_placed;

    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         idx_q;
    logic [3:0]         an_q;
    logic [6:0]         seg_q, seg_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            shcnt_q <= '0;
            disp_q  <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            shcnt_q <= shcnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        shcnt_d = shcnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        shifted = {dabble_adjust(bcd_q), mag_q} << 1;
        case (state_q)
            ST_SHIFT: begin
                bcd_d   = shifted[BCD_W+15:16];
                mag_d   = shifted[15:0];
                shcnt_d = shcnt_q + 4'd1;
                if (shcnt_q == 4'd15) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                disp_d  = fmt_code;
                ovf_d   = fmt_ovf;
                state_d = ST_IDLE;
            end
            default: ;
        endcase
        // A new load always wins, even mid-conversion or in the commit cycle.
        if (load) begin
            sign_d  = product[15];
            mag_d   = product[15] ? (~product + 16'd1) : product;
            bcd_d   = '0;
            shcnt_d = '0;
            state_d = ST_SHIFT;
        end
    end

    always_comb begin
        fmt_code    = '0;
        fmt_ovf     = 1'b0;
        fmt_lead    = 1'b1;
        fmt_placed  = 1'b0;
        fmt_code[0] = bcd_q[3:0];
        for (int i = 3; i >= 1; i--) begin
            if (BLANK_ZEROS && fmt_lead && bcd_q[i*4 +: 4] == 4'd0) begin
                fmt_code[i] = DIG_BLANK;
            end else begin
                fmt_code[i] = bcd_q[i*4 +: 4];
                fmt_lead    = 1'b0;
            end
        end
        // Minus sits in the lowest blanked slot, i.e. just left of the leading digit.
        if (sign_q) begin
            if (BLANK_ZEROS) begin
                for (int i = 1; i <= 3; i++) begin
                    if (!fmt_placed && fmt_code[i] == DIG_BLANK) begin
                        fmt_code[i] = DIG_MINUS;
                        fmt_placed  = 1'b1;
                    end
                end
            end else begin
                fmt_code[3] = DIG_MINUS;
            end
        end
        if (sign_q ? (bcd_q[BCD_W-1:12] != '0) : (bcd_q[BCD_W-1:16] != '0)) begin
            fmt_code = {4{DIG_MINUS}};
            fmt_ovf  = 1'b1;
        end
    end

    seg7_decoder u_dec (
        .code_i (disp_q[idx_q]),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            if (cnt_q == CNT_W'(REFRESH_CNT - 1)) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_dec;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_product_display.sv
// Scoreboard bench for product_display with a fast scan (REFRESH_CNT=4).
module tb_product_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] product;
    logic        load;
    logic        busy, ovf, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0][6:0] seg;
        logic            ovf;
        int              val;
    } exp_t;

    exp_t sb[$];

    product_display #(.REFRESH_CNT(4), .BLANK_ZEROS(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .product (product),
        .load    (load),
        .busy    (busy),
        .ovf     (ovf),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] segof(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(int v);
        exp_t e;
        int   m, nd, pw;
        bit   neg;
        neg   = v < 0;
        m     = neg ? -v : v;
        e.val = v;
        e.ovf = 1'b0;
        if ((!neg && m > 9999) || (neg && m > 999)) begin
            for (int i = 0; i < 4; i++) e.seg[i] = 7'h3F;
            e.ovf = 1'b1;
            return e;
        end
        nd = (m >= 1000) ? 4 : (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
        pw = 1;
        for (int i = 0; i < 4; i++) begin
            e.seg[i] = (i < nd) ? segof((m / pw) % 10) : 7'h7F;
            pw = pw * 10;
        end
        if (neg) e.seg[nd] = 7'h3F;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int v, bit supersede);
        if (supersede && sb.size() > 0) void'(sb.pop_back());
        sb.push_back(model(v));
        product = 16'(v);
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic wait_done(string name, int lat);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, n, lat);
        end
    endtask

    task automatic check_disp(string name);
        exp_t            e;
        logic [3:0][6:0] got;
        bit              bad_an;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s ovf (val %0d) got %b want %b", name, e.val, ovf, e.ovf);
        end
        got    = 'x;
        bad_an = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            case (an)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: bad_an = 1'b1;
            endcase
        end
        checks++;
        if (bad_an) begin
            errors++;
            $display("FAIL %s anode not one-hot-low during scan", name);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (got[d] !== e.seg[d]) begin
                errors++;
                $display("FAIL %s digit%0d (val %0d) got %h want %h", name, d, e.val, got[d], e.seg[d]);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        rst_n = 1'b0; load = 1'b0; product = '0;
        repeat (3) tick();
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || busy !== 1'b0 || ovf !== 1'b0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got an=%b seg=%h busy=%b ovf=%b dp=%b want 1111 7f 0 0 1",
                     an, seg, busy, ovf, dp);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_an  = ~(4'b0001 << (k / 4));
            exp_seg = (k < 4) ? 7'h40 : 7'h7F;
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL reset_scan k=%0d got an=%b seg=%h want an=%b seg=%h",
                         k, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_convert();
        do_load(1234, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL convert busy_after_load got %b want 1", busy);
        end
        wait_done("convert_1234", 17);
        check_disp("convert_1234");
    endtask

    task automatic test_negative();
        do_load(-56, 1'b0);
        wait_done("neg_56", 17);
        check_disp("neg_56");
        do_load(-999, 1'b0);
        wait_done("neg_999", 17);
        check_disp("neg_999");
        do_load(-7, 1'b0);
        wait_done("neg_7", 17);
        check_disp("neg_7");
    endtask

    task automatic test_overflow();
        int vals[4] = '{16384, -1000, -32768, 0};
        foreach (vals[i]) begin
            do_load(vals[i], 1'b0);
            wait_done("ovf_case", 17);
            check_disp("ovf_case");
        end
        do_load(9999, 1'b0);
        wait_done("max_9999", 17);
        check_disp("max_9999");
        do_load(10000, 1'b0);
        wait_done("over_10000", 17);
        check_disp("over_10000");
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen7;
        do_load(7, 1'b0);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy_between got %b want 1", busy);
        end
        do_load(9, 1'b1);
        n = 0;
        seen7 = 1'b0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
            if (an === 4'b1110 && seg === 7'h78) seen7 = 1'b1;
        end
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL b2b busy_cycles got %0d want 17", n);
        end
        check_disp("b2b_9");
        checks++;
        if (seen7) begin
            errors++;
            $display("FAIL b2b interrupted value 7 displayed got 1 want 0");
        end
    endtask

    task automatic test_reset_abort();
        do_load(1234, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || an !== 4'b1111 || seg !== 7'h7F) begin
            errors++;
            $display("FAIL abort_reset got busy=%b an=%b seg=%h want 0 1111 7f", busy, an, seg);
        end
        rst_n = 1'b1;
        void'(sb.pop_back());
        sb.push_back(model(0));
        check_disp("abort_zero");
        do_load(42, 1'b0);
        wait_done("abort_then_42", 17);
        check_disp("abort_then_42");
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            do_load(int'($signed(r)), 1'b0);
            wait_done("random", 17);
            check_disp("random");
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
